// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_mmio
//  Description : Memory-mapped 8N1 UART transmitter. CPU stores to TXDATA
//                queue bytes in a FIFO; a serialiser drains them onto
//                uart_tx. STATUS exposes {overflow, busy, full, empty}.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                cpu_addr/we/wdata/re - CPU data-store bus access
//                cpu_rdata       - combinational load data
//                uart_tx         - registered serial line, idle high
//                tx_busy         - FIFO non-empty or frame in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e             state_q,   state_d;
    logic [BAUD_W-1:0]  baud_q,    baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q,   shift_d;
    logic               tx_q,      tx_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               ovf_q,     ovf_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic w_hit, w_sel_status, w_push_req, w_push_ok, w_clr_ovf;
    logic w_empty, w_full, w_busy, w_baud_end, w_pop;
    logic [7:0] w_fifo_out;

    // Address bits [1:0] and the upper store-data bits have no function here.
    logic unused_ok;
    assign unused_ok = ^{cpu_addr[1:0], cpu_wdata[31:8]};

    // ------------------------------------------------------------------ decode
    assign w_hit        = (cpu_addr[31:3] == BASE_ADDR[31:3]);
    assign w_sel_status = cpu_addr[2];
    assign w_push_req   = cpu_we & w_hit & ~w_sel_status;
    assign w_clr_ovf    = cpu_we & w_hit &  w_sel_status & cpu_wdata[3];

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_busy     = (state_q != S_IDLE) | ~w_empty;
    assign w_baud_end = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign w_fifo_out = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the serialiser pops in the
    // same cycle, since a slot frees up at that edge.
    assign w_push_ok = w_push_req & (~w_full | w_pop);

    always_comb begin
        cpu_rdata = 32'h0;
        if (cpu_re && w_hit && w_sel_status)
            cpu_rdata = {28'h0, ovf_q, w_busy, w_full, w_empty};
    end

    assign uart_tx = tx_q;
    assign tx_busy = w_busy;

    // -------------------------------------------------------------------- fifo
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (w_push_ok)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_push_ok && !w_pop)
            count_d = count_q + CNT_W'(1);
        else if (!w_push_ok && w_pop)
            count_d = count_q - CNT_W'(1);
        if (w_push_req && !w_push_ok)
            ovf_d = 1'b1;
        else if (w_clr_ovf)
            ovf_d = 1'b0;
    end

    // Storage array needs no reset: pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            mem_q[wr_ptr_q] <= cpu_wdata[7:0];
    end

    // -------------------------------------------------------------- serialiser
    // tx_d is computed alongside the state transition so the registered line
    // changes on the same edge the FSM enters each bit period.
    always_comb begin
        state_d   = state_q;
        baud_d    = w_baud_end ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_fifo_out;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    // Back-to-back frames: next start bit follows the stop
                    // bit with no idle cycle.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_fifo_out;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h0;
            tx_q      <= 1'b1;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_mmio
//  Description : Self-checking bench for uart_tx_mmio (CLK_DIV=4, depth 8).
//                Register-access vector table plus directed frame sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE   = 32'hF000_0000;
    localparam logic [31:0] STATUS = 32'hF000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; compares combinational load data, returns at next negedge.
    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        cpu_re   = 1'b1;
        cpu_addr = a;
        #1;
        chk(name, cpu_rdata, exp);
        cpu_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    // Push n bytes on consecutive cycles and check every bit period of the
    // resulting back-to-back frames: start(0), LSB..MSB, stop(1), 4 cycles each.
    task automatic run_frames(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        logic [7:0] bs [3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    cpu_we    = 1'b1;
                    cpu_addr  = BASE;
                    cpu_wdata = {24'h0, bs[i]};
                    @(posedge clk);
                    @(negedge clk);
                end
                cpu_we = 1'b0;
            end
            begin
                @(posedge clk);
                @(negedge clk);
                chk("tx_before_start", {31'h0, uart_tx}, 32'h1);
                for (int f = 0; f < n; f++) begin
                    for (int j = 0; j < 10; j++) begin
                        for (int c = 0; c < 4; c++) begin
                            logic e;
                            @(negedge clk);
                            e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bs[f][j-1];
                            chk($sformatf("frame%0d_bit%0d_cyc%0d", f, j, c),
                                {31'h0, uart_tx}, {31'h0, e});
                            chk($sformatf("busy_f%0d_b%0d_c%0d", f, j, c),
                                {31'h0, tx_busy}, 32'h1);
                        end
                    end
                end
            end
        join
        // Stop bit ends at the next edge; FSM then idles.
        @(negedge clk);
        chk("busy_after_frames", {31'h0, tx_busy}, 32'h0);
        rd("status_after_frames", STATUS, 32'h1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0; cpu_re = 1'b0;

        //              we    re    addr          wdata         exp_rdata
        vecs[0]  = '{1'b0, 1'b1, BASE,         32'h0,        32'h0};  // TXDATA read
        vecs[1]  = '{1'b0, 1'b1, STATUS,       32'h0,        32'h1};  // reset STATUS
        vecs[2]  = '{1'b0, 1'b1, 32'hF000_0008, 32'h0,       32'h0};  // BASE+8 read
        vecs[3]  = '{1'b1, 1'b0, 32'hF000_0008, 32'h55,      32'h0};  // BASE+8 write
        vecs[4]  = '{1'b1, 1'b0, 32'hEFFF_FFFC, 32'h55,      32'h0};  // BASE-4 write
        vecs[5]  = '{1'b0, 1'b1, 32'hEFFF_FFFC, 32'h0,       32'h0};  // BASE-4 read
        vecs[6]  = '{1'b0, 1'b1, 32'hF000_0007, 32'h0,       32'h1};  // addr[1:0] ignored
        vecs[7]  = '{1'b1, 1'b0, STATUS,       32'hFFFF_FFFF, 32'h0}; // STATUS write: no push
        vecs[8]  = '{1'b0, 1'b1, STATUS,       32'h0,        32'h1};
        vecs[9]  = '{1'b0, 1'b0, STATUS,       32'h0,        32'h0};  // re=0 -> 0
        vecs[10] = '{1'b1, 1'b0, 32'hF000_000C, 32'hAA,      32'h0};  // miss write
        vecs[11] = '{1'b0, 1'b1, STATUS,       32'h0,        32'h1};

        repeat (3) @(negedge clk);
        chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("reset_tx_busy", {31'h0, tx_busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Register-access table (reset state and address decoding)
        for (int i = 0; i < 12; i++) begin
            cpu_we    = vecs[i].we;
            cpu_re    = vecs[i].re;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            @(posedge clk);
            @(negedge clk);
            cpu_we = 1'b0;
            cpu_re = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("miss_idle_tx%0d", i), {31'h0, uart_tx}, 32'h1);
            chk($sformatf("miss_idle_busy%0d", i), {31'h0, tx_busy}, 32'h0);
        end

        // Single frame, then three back-to-back frames
        run_frames(1, 8'h55, 8'h00, 8'h00);
        run_frames(3, 8'h41, 8'h42, 8'h43);

        // Overflow: 10 consecutive pushes, 10th dropped
        for (int i = 0; i < 10; i++) begin
            cpu_we    = 1'b1;
            cpu_addr  = BASE;
            cpu_wdata = 32'h30 + i;
            @(posedge clk);
            @(negedge clk);
        end
        cpu_we = 1'b0;
        rd("status_overflow", STATUS, 32'hE);
        wr(STATUS, 32'h8);
        rd("status_ovf_cleared", STATUS, 32'h6);
        pulse_reset();
        rd("status_after_drain_reset", STATUS, 32'h1);

        // Reset during DATA bit 3 of 0x00 (line low there)
        wr(BASE, 32'h00);
        repeat (18) @(negedge clk);
        chk("data_bit3_low", {31'h0, uart_tx}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_tx_high", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        rd("status_after_midframe_reset", STATUS, 32'h1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_tx%0d", i), {31'h0, uart_tx}, 32'h1);
        end
        chk("post_reset_busy", {31'h0, tx_busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
